// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: PC and pipeline-register enables, bubble
// flushes, memory-access freeze sequencing and a saturating stall counter.
module pipe_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             status_write,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             status_en,
  output logic             mem_start,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_cnt
);

  // state    | meaning
  // RUN      | pipeline advancing; a mem_req launches an access and freezes
  // MEM_WAIT | access in flight, everything frozen, cnt counts down to 0
  // MEM_DONE | result captured; pipeline advances, held branch/hazard apply
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  localparam logic [3:0]       LAT_M1  = 4'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [3:0] cnt;
  logic       normal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req) begin
            state <= MEM_WAIT;
            cnt   <= LAT_M1;
          end
        end
        MEM_WAIT: begin
          if (cnt == 4'd0) state <= MEM_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        MEM_DONE: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Reset gates every control output so nothing loads while rst is high.
  assign normal = !rst && (((state == RUN) && !mem_req) || (state == MEM_DONE));

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    status_en   = 1'b0;
    mem_start   = !rst && (state == RUN) && mem_req;
    mem_done    = !rst && (state == MEM_DONE);
    if (normal) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      status_en = status_write;
      if (branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a CNT_W=4 instance
// sharing the same stimulus, used to observe stall counter saturation.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst, hazard, branch_taken, mem_req, status_write;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, status_en, mem_start, mem_done;
  logic [15:0] stall_cnt;
  logic pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
  logic if_id_flush4, id_ex_flush4, status_en4, mem_start4, mem_done4;
  logic [3:0] stall_cnt4;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, status, start, done}
  localparam logic [9:0] ZERO   = 10'b00000_00000;
  localparam logic [9:0] IDLE   = 10'b11111_00000;
  localparam logic [9:0] IDLE_S = 10'b11111_00100;
  localparam logic [9:0] BRANCH = 10'b11111_11000;
  localparam logic [9:0] HAZ    = 10'b00111_01000;
  localparam logic [9:0] START  = 10'b00000_00010;
  localparam logic [9:0] DONE   = 10'b11111_00001;
  localparam logic [9:0] DONE_H = 10'b00111_01001;

  logic [9:0] obs;
  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, status_en, mem_start, mem_done};

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .status_write(status_write),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .status_en(status_en), .mem_start(mem_start), .mem_done(mem_done),
    .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.MEM_LAT(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .status_write(status_write),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4),
    .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .status_en(status_en4), .mem_start(mem_start4), .mem_done(mem_done4),
    .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp_cnt++;
    assert (o === e) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Drive one cycle's inputs at negedge, then check outputs and the counters
  // as they stand before this cycle's rising edge.
  task automatic cyc(input logic h, input logic b, input logic m, input logic s,
                     input logic [9:0] ev, input int es, input string tag);
    @(negedge clk);
    hazard = h; branch_taken = b; mem_req = m; status_write = s;
    #1;
    chk({tag, "_out"}, 32'(obs), 32'(ev));
    chk({tag, "_cnt"}, 32'(stall_cnt), 32'(es));
    chk({tag, "_cnt4"}, 32'(stall_cnt4), 32'((es > 15) ? 15 : es));
  endtask

  initial begin
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b1; mem_req = 1'b1; status_write = 1'b1;
    #2;
    chk("rst_out", 32'(obs), 32'(ZERO));
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; status_write = 1'b0;
    #1;
    chk("release_out", 32'(obs), 32'(IDLE));
    chk("release_cnt", 32'(stall_cnt), 32'd0);

    cyc(0, 0, 0, 0, IDLE,   0, "idle");
    cyc(0, 0, 0, 1, IDLE_S, 0, "status");

    // Memory access, MEM_LAT=4: start + 4 wait cycles frozen, then done.
    cyc(0, 0, 1, 0, START, 0, "mem0");
    cyc(1, 1, 0, 1, ZERO,  1, "wait1");
    cyc(1, 1, 0, 1, ZERO,  2, "wait2");
    cyc(1, 1, 0, 1, ZERO,  3, "wait3");
    cyc(1, 1, 0, 1, ZERO,  4, "wait4");
    cyc(0, 0, 1, 0, DONE,  5, "done");
    cyc(0, 0, 0, 0, IDLE,  5, "after_done");

    cyc(1, 1, 0, 0, BRANCH, 5, "br_haz");
    cyc(0, 0, 0, 0, IDLE,   5, "br_after");

    cyc(1, 0, 0, 0, HAZ,  5, "haz1");
    cyc(1, 0, 0, 0, HAZ,  6, "haz2");
    cyc(1, 0, 0, 0, HAZ,  7, "haz3");
    cyc(0, 0, 0, 0, IDLE, 8, "haz_after");

    // Hazard held across the freeze applies in MEM_DONE.
    cyc(0, 0, 1, 0, START,  8,  "m2_start");
    cyc(0, 0, 0, 0, ZERO,   9,  "m2_w1");
    cyc(0, 0, 0, 0, ZERO,   10, "m2_w2");
    cyc(0, 0, 0, 0, ZERO,   11, "m2_w3");
    cyc(0, 0, 0, 0, ZERO,   12, "m2_w4");
    cyc(1, 0, 0, 0, DONE_H, 13, "m2_done_haz");
    cyc(0, 0, 0, 0, IDLE,   14, "m2_after");

    // Reset mid-cycle while MEM_WAIT holds cnt=2.
    cyc(0, 0, 1, 0, START, 14, "m3_start");
    cyc(0, 0, 0, 0, ZERO,  15, "m3_w1");
    cyc(0, 0, 0, 0, ZERO,  16, "m3_w2");
    #1 rst = 1'b1;
    #1;
    chk("midrst_out", 32'(obs), 32'(ZERO));
    chk("midrst_cnt", 32'(stall_cnt), 32'd0);
    chk("midrst_cnt4", 32'(stall_cnt4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_out", 32'(obs), 32'(IDLE));
    chk("postrst_cnt", 32'(stall_cnt), 32'd0);
    cyc(0, 0, 0, 0, IDLE, 0, "postrst1");
    cyc(0, 0, 0, 0, IDLE, 0, "postrst2");
    cyc(0, 0, 0, 0, IDLE, 0, "postrst3");

    // Continuous hazard: 16-bit counter reaches 20, 4-bit counter sticks at 15.
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, HAZ, i, "sat");
    cyc(0, 0, 0, 0, IDLE, 20, "sat_end");
    cyc(0, 0, 0, 0, IDLE, 20, "sat_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
